alu_mem_stage: RTL and testbench
================================

Name: alu_mem_stage

Overview:
- Parametrised ALU→MEM pipeline stage. Replaces the bare ALU/MEM register with a valid/ready register plus a one-entry skid buffer, flush, and byte-lane generation for sub-word loads/stores.
- Detects misalignment and exports a forwarding tap for the decode-stage bypass.
- Sits between the ALU/DEC_ALU outputs and the data cache / MEM_WB stage.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register-file address width.
- BE_W, DATA_W/8, byte-enable width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill all held and incoming ops (branch/trap redirect).
- inValid  in  1  upstream op valid.
- inReady  out  1  stage can accept an op.
- dataIn  in  DATA_W  ALU result (memory address, or writeback value).
- dataRs2In  in  DATA_W  store data.
- writeEnableIn  in  1  op writes the register file.
- dataCacheReadEnableIn  in  1  op is a load.
- dataCacheWriteEnableIn  in  1  op is a store.
- memSizeIn  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- memUnsignedIn  in  1  zero-extend load.
- writeBackAddrIn  in  REG_AW  destination register.
- outValid  out  1  stage holds a valid op.
- outReady  in  1  downstream accepts.
- dataOut  out  DATA_W  registered ALU result.
- dataRs2Out  out  DATA_W  store data shifted into its byte lane.
- byteEnableOut  out  BE_W  lane enables for the cache.
- dataCacheReadEnableOut  out  1  gated load strobe.
- dataCacheWriteEnableOut  out  1  gated store strobe.
- writeEnableOut  out  1  gated register writeback.
- writeBackAddrOut  out  REG_AW  destination register.
- memSizeOut  out  2  registered size.
- memUnsignedOut  out  1  registered unsigned flag.
- misalignOut  out  1  op faulted on alignment.
- fwdValid  out  1  forwarding tap valid.
- fwdAddr  out  REG_AW  forwarding register.
- fwdData  out  DATA_W  forwarding value.

Behaviour:
- Reset (async, rst_n=0):
  - Main and skid valid bits = 0; inReady = 1.
  - All data, address, size and enable registers = 0, so every output reads 0.
  - Reset mid-transfer discards all held ops.
- Handshake:
  - Transfer in when inValid&inReady; transfer out when outValid&outReady.
  - Latency: 1 cycle from accept to outValid.
  - inReady is a register: inReady = !skidValid. No combinational in→out ready path.
- Main register loads when (!outValid | outReady):
  - Source is the skid entry if skidValid, otherwise the input.
  - If skidValid, the skid is consumed and a simultaneous input is captured into the skid.
- Main full and outReady=0 with an accepted input: the input goes to the skid; skidValid=1, so inReady=0 next cycle.
- Back-to-back throughput is 1 op/cycle while outReady=1.
- Held output is stable: payload does not change while outValid&!outReady.
- Flush:
  - Next edge clears both valid bits; inReady=1.
  - An input presented in the flush cycle is dropped.
  - Flush has priority over all other updates.
- Lane logic is computed at capture and stored:
  - off = dataIn[log2(BE_W)-1:0].
  - size bytes n = 1<<memSizeIn.
  - byteEnable = ((1<<n)-1) << off.
  - dataRs2Out = dataRs2In << (8*off).
- Misalignment:
  - Condition: (load|store) & (off mod n != 0), or size 3 with DATA_W=32.
  - misalignOut=1; cache strobes and writeEnableOut forced 0; byteEnableOut=0.
  - The op still retires downstream as valid.
- Gating:
  - dataCacheReadEnableOut, dataCacheWriteEnableOut and writeEnableOut are each ANDed with outValid.
  - When outValid=0, byteEnableOut=0.
- Forwarding:
  - fwdValid = outValid & writeEnableOut & !dataCacheReadEnableOut & (writeBackAddrOut != 0).
  - fwdAddr = writeBackAddrOut; fwdData = dataOut.
  - Load results are never forwarded from this stage.
- Non-memory ops (no load/store): byteEnableOut=0 and misalignOut=0, regardless of memSizeIn.

Test Plan:
- Reset then single ALU op (dataIn=0x1234, wb x5, outReady=1):
  - outValid=1 one cycle after accept, dataOut=0x1234.
  - fwdValid=1, fwdAddr=5; next cycle outValid=0.
- Store byte, dataIn=0x1003, dataRs2In=0xAB, DATA_W=32:
  - byteEnableOut=4'b1000, dataRs2Out=0xAB000000, dataCacheWriteEnableOut=1.
- Store half to 0x1001:
  - misalignOut=1, dataCacheWriteEnableOut=0, byteEnableOut=0, outValid=1.
- Backpressure: 3 ops A,B,C, outReady=0 for 3 cycles:
  - A held in main, B in skid, inReady=0 so C stalls.
  - Release outReady: A, B, C exit in consecutive cycles with no loss or duplication.
- Flush with main+skid full and inValid=1:
  - Next cycle outValid=0, inReady=1, no cache strobe asserted.
- Load to x7:
  - dataCacheReadEnableOut=1, fwdValid=0.
- Op to x0 with writeEnable:
  - fwdValid=0.
- Async reset asserted mid-stall:
  - Outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_mem_stage.sv
// alu_mem_stage: ALU -> MEM pipeline register with valid/ready handshake,
// a one-entry skid buffer, flush, byte-lane generation and misalignment
// detection for sub-word loads/stores, plus a forwarding tap for decode.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   flush                   drop all held and incoming ops
//   inValid / inReady       upstream handshake (inReady = !skid valid)
//   dataIn, dataRs2In       ALU result / address and store data
//   writeEnableIn, dataCacheReadEnableIn, dataCacheWriteEnableIn,
//   memSizeIn, memUnsignedIn, writeBackAddrIn   op control from ALU
//   outValid / outReady     downstream handshake
//   dataOut, dataRs2Out, byteEnableOut, dataCache*EnableOut,
//   writeEnableOut, writeBackAddrOut, memSizeOut, memUnsignedOut,
//   misalignOut             registered op towards cache / MEM_WB
//   fwdValid, fwdAddr, fwdData   decode-stage bypass tap
module alu_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataRs2In,
  input  logic              writeEnableIn,
  input  logic              dataCacheReadEnableIn,
  input  logic              dataCacheWriteEnableIn,
  input  logic [1:0]        memSizeIn,
  input  logic              memUnsignedIn,
  input  logic [REG_AW-1:0] writeBackAddrIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] dataOut,
  output logic [DATA_W-1:0] dataRs2Out,
  output logic [BE_W-1:0]   byteEnableOut,
  output logic              dataCacheReadEnableOut,
  output logic              dataCacheWriteEnableOut,
  output logic              writeEnableOut,
  output logic [REG_AW-1:0] writeBackAddrOut,
  output logic [1:0]        memSizeOut,
  output logic              memUnsignedOut,
  output logic              misalignOut,
  output logic              fwdValid,
  output logic [REG_AW-1:0] fwdAddr,
  output logic [DATA_W-1:0] fwdData
);

  localparam int OFFW = $clog2(BE_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rs2;
    logic [BE_W-1:0]   be;
    logic              re;
    logic              we;
    logic              wen;
    logic [REG_AW-1:0] wb;
    logic [1:0]        size;
    logic              uns;
    logic              mis;
  } op_t;

  op_t  in_op;
  op_t  main_q, main_d;
  op_t  skid_q, skid_d;
  logic valid_q, valid_d;
  logic skid_valid_q, skid_valid_d;

  logic [OFFW-1:0] off;
  logic [OFFW-1:0] align_mask;
  logic [BE_W-1:0] size_mask;
  logic            is_mem;
  logic            mis;
  logic            accept;
  logic            main_load;

  // Lane and alignment decode on the incoming op; the result is stored so
  // the cache sees registered enables and already-shifted store data.
  always_comb begin
    off        = dataIn[OFFW-1:0];
    align_mask = '0;
    size_mask  = '0;
    case (memSizeIn)
      2'd0: begin align_mask = '0;          size_mask = BE_W'(4'h1);  end
      2'd1: begin align_mask = OFFW'(1);    size_mask = BE_W'(4'h3);  end
      2'd2: begin align_mask = OFFW'(3);    size_mask = BE_W'(4'hF);  end
      default: begin align_mask = OFFW'(7); size_mask = '1;           end
    endcase
    is_mem = dataCacheReadEnableIn | dataCacheWriteEnableIn;
    mis    = is_mem & (((off & align_mask) != '0) ||
                       (memSizeIn == 2'd3 && DATA_W == 32));

    in_op.data = dataIn;
    in_op.rs2  = dataRs2In << {off, 3'b000};
    in_op.be   = (is_mem && !mis) ? (size_mask << off) : '0;
    in_op.re   = dataCacheReadEnableIn & ~mis;
    in_op.we   = dataCacheWriteEnableIn & ~mis;
    in_op.wen  = writeEnableIn & ~mis;
    in_op.wb   = writeBackAddrIn;
    in_op.size = memSizeIn;
    in_op.uns  = memUnsignedIn;
    in_op.mis  = mis;
  end

  assign inReady   = ~skid_valid_q;
  assign accept    = inValid & inReady;
  assign main_load = ~valid_q | outReady;

  // The skid drains into main whenever main can load; because inReady is
  // derived from the skid bit, an accept with a full skid cannot occur, but
  // the refill path is kept so the structure stays correct if that changes.
  always_comb begin
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = in_op;
      end else begin
        valid_d = accept;
        if (accept) main_d = in_op;
      end
    end else if (accept) begin
      skid_d       = in_op;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign outValid                = valid_q;
  assign dataOut                 = main_q.data;
  assign dataRs2Out              = main_q.rs2;
  assign byteEnableOut           = valid_q ? main_q.be : '0;
  assign dataCacheReadEnableOut  = valid_q & main_q.re;
  assign dataCacheWriteEnableOut = valid_q & main_q.we;
  assign writeEnableOut          = valid_q & main_q.wen;
  assign writeBackAddrOut        = main_q.wb;
  assign memSizeOut              = main_q.size;
  assign memUnsignedOut          = main_q.uns;
  assign misalignOut             = valid_q & main_q.mis;

  assign fwdValid = writeEnableOut & ~dataCacheReadEnableOut & (main_q.wb != '0);
  assign fwdAddr  = main_q.wb;
  assign fwdData  = main_q.data;

endmodule

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] dataIn;
  logic [31:0] dataRs2In;
  logic        writeEnableIn;
  logic        dataCacheReadEnableIn;
  logic        dataCacheWriteEnableIn;
  logic [1:0]  memSizeIn;
  logic        memUnsignedIn;
  logic [4:0]  writeBackAddrIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] dataOut;
  logic [31:0] dataRs2Out;
  logic [3:0]  byteEnableOut;
  logic        dataCacheReadEnableOut;
  logic        dataCacheWriteEnableOut;
  logic        writeEnableOut;
  logic [4:0]  writeBackAddrOut;
  logic [1:0]  memSizeOut;
  logic        memUnsignedOut;
  logic        misalignOut;
  logic        fwdValid;
  logic [4:0]  fwdAddr;
  logic [31:0] fwdData;

  int total = 0;
  int bad   = 0;

  alu_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .dataRs2In(dataRs2In),
    .writeEnableIn(writeEnableIn),
    .dataCacheReadEnableIn(dataCacheReadEnableIn),
    .dataCacheWriteEnableIn(dataCacheWriteEnableIn),
    .memSizeIn(memSizeIn), .memUnsignedIn(memUnsignedIn),
    .writeBackAddrIn(writeBackAddrIn),
    .outValid(outValid), .outReady(outReady),
    .dataOut(dataOut), .dataRs2Out(dataRs2Out),
    .byteEnableOut(byteEnableOut),
    .dataCacheReadEnableOut(dataCacheReadEnableOut),
    .dataCacheWriteEnableOut(dataCacheWriteEnableOut),
    .writeEnableOut(writeEnableOut),
    .writeBackAddrOut(writeBackAddrOut),
    .memSizeOut(memSizeOut), .memUnsignedOut(memUnsignedOut),
    .misalignOut(misalignOut),
    .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge, outputs are checked there too.
  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] r2,
                       input logic wen, input logic re, input logic we,
                       input logic [1:0] sz, input logic [4:0] wb);
    inValid                = v;
    dataIn                 = d;
    dataRs2In              = r2;
    writeEnableIn          = wen;
    dataCacheReadEnableIn  = re;
    dataCacheWriteEnableIn = we;
    memSizeIn              = sz;
    memUnsignedIn          = 1'b0;
    writeBackAddrIn        = wb;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; outReady = 1'b1; idle();
    repeat (2) @(negedge clk);
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
    total++; if (inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady got=%b exp=1", inReady); end
    total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL reset_dataOut got=%h exp=0", dataOut); end
    total++; if (byteEnableOut !== 4'h0 || fwdValid !== 1'b0) begin bad++; $display("FAIL reset_be_fwd got=%h/%b exp=0/0", byteEnableOut, fwdValid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_op();
    outReady = 1'b1;
    drive(1'b1, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd5);
    @(negedge clk);
    idle();
    total++; if (outValid !== 1'b1 || dataOut !== 32'h1234) begin bad++; $display("FAIL alu_out got=%b/%h exp=1/00001234", outValid, dataOut); end
    total++; if (fwdValid !== 1'b1 || fwdAddr !== 5'd5 || fwdData !== 32'h1234) begin bad++; $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/00001234", fwdValid, fwdAddr, fwdData); end
    total++; if (byteEnableOut !== 4'h0 || misalignOut !== 1'b0) begin bad++; $display("FAIL alu_nomem got=%h/%b exp=0/0", byteEnableOut, misalignOut); end
    @(negedge clk);
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL alu_drain got=%b exp=0", outValid); end
  endtask

  task automatic test_store_lanes();
    outReady = 1'b1;
    drive(1'b1, 32'h1003, 32'hAB, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 32'h1002, 32'hBEEF, 1'b0, 1'b0, 1'b1, 2'd1, 5'd0);
    total++; if (byteEnableOut !== 4'b1000 || dataRs2Out !== 32'hAB000000) begin bad++; $display("FAIL sb_lanes got=%b/%h exp=1000/ab000000", byteEnableOut, dataRs2Out); end
    total++; if (dataCacheWriteEnableOut !== 1'b1 || misalignOut !== 1'b0) begin bad++; $display("FAIL sb_strobe got=%b/%b exp=1/0", dataCacheWriteEnableOut, misalignOut); end
    @(negedge clk);
    drive(1'b1, 32'h1000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    total++; if (byteEnableOut !== 4'b1100 || dataRs2Out !== 32'hBEEF0000) begin bad++; $display("FAIL sh_lanes got=%b/%h exp=1100/beef0000", byteEnableOut, dataRs2Out); end
    @(negedge clk);
    drive(1'b1, 32'h1001, 32'h55, 1'b0, 1'b0, 1'b1, 2'd1, 5'd0);
    total++; if (byteEnableOut !== 4'b1111 || dataRs2Out !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_lanes got=%b/%h exp=1111/deadbeef", byteEnableOut, dataRs2Out); end
    @(negedge clk);
    drive(1'b1, 32'h1004, 32'h0, 1'b1, 1'b1, 1'b0, 2'd3, 5'd9);
    total++; if (misalignOut !== 1'b1 || dataCacheWriteEnableOut !== 1'b0 || byteEnableOut !== 4'h0 || outValid !== 1'b1) begin bad++; $display("FAIL sh_misalign got=%b/%b/%h/%b exp=1/0/0/1", misalignOut, dataCacheWriteEnableOut, byteEnableOut, outValid); end
    @(negedge clk);
    idle();
    total++; if (misalignOut !== 1'b1 || dataCacheReadEnableOut !== 1'b0 || writeEnableOut !== 1'b0 || fwdValid !== 1'b0) begin bad++; $display("FAIL dword_misalign got=%b/%b/%b/%b exp=1/0/0/0", misalignOut, dataCacheReadEnableOut, writeEnableOut, fwdValid); end
    @(negedge clk);
  endtask

  task automatic test_load_and_x0();
    outReady = 1'b1;
    drive(1'b1, 32'h2002, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 5'd7);
    @(negedge clk);
    drive(1'b1, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    total++; if (dataCacheReadEnableOut !== 1'b1 || fwdValid !== 1'b0 || byteEnableOut !== 4'b1100) begin bad++; $display("FAIL load_x7 got=%b/%b/%b exp=1/0/1100", dataCacheReadEnableOut, fwdValid, byteEnableOut); end
    total++; if (writeEnableOut !== 1'b1 || writeBackAddrOut !== 5'd7 || memSizeOut !== 2'd1) begin bad++; $display("FAIL load_ctl got=%b/%0d/%0d exp=1/7/1", writeEnableOut, writeBackAddrOut, memSizeOut); end
    @(negedge clk);
    drive(1'b1, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 2'd3, 5'd4);
    total++; if (fwdValid !== 1'b0 || writeEnableOut !== 1'b1) begin bad++; $display("FAIL x0_fwd got=%b/%b exp=0/1", fwdValid, writeEnableOut); end
    @(negedge clk);
    idle();
    total++; if (misalignOut !== 1'b0 || byteEnableOut !== 4'h0 || fwdValid !== 1'b1) begin bad++; $display("FAIL nonmem_size3 got=%b/%h/%b exp=0/0/1", misalignOut, byteEnableOut, fwdValid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    outReady = 1'b1;
    drive(1'b1, 32'hA1, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd1);
    @(negedge clk);
    drive(1'b1, 32'hA2, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd2);
    total++; if (dataOut !== 32'hA1 || outValid !== 1'b1 || inReady !== 1'b1) begin bad++; $display("FAIL b2b_1 got=%h/%b/%b exp=a1/1/1", dataOut, outValid, inReady); end
    @(negedge clk);
    drive(1'b1, 32'hA3, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd3);
    total++; if (dataOut !== 32'hA2 || outValid !== 1'b1) begin bad++; $display("FAIL b2b_2 got=%h/%b exp=a2/1", dataOut, outValid); end
    @(negedge clk);
    idle();
    total++; if (dataOut !== 32'hA3 || outValid !== 1'b1) begin bad++; $display("FAIL b2b_3 got=%h/%b exp=a3/1", dataOut, outValid); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    drive(1'b1, 32'hAAAA, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd10);
    @(negedge clk);
    drive(1'b1, 32'hBBBB, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd11);
    total++; if (dataOut !== 32'hAAAA || inReady !== 1'b1) begin bad++; $display("FAIL bp_a got=%h/%b exp=aaaa/1", dataOut, inReady); end
    @(negedge clk);
    drive(1'b1, 32'hCCCC, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd12);
    total++; if (dataOut !== 32'hAAAA || inReady !== 1'b0 || outValid !== 1'b1) begin bad++; $display("FAIL bp_skid got=%h/%b/%b exp=aaaa/0/1", dataOut, inReady, outValid); end
    @(negedge clk);
    total++; if (dataOut !== 32'hAAAA || inReady !== 1'b0 || writeBackAddrOut !== 5'd10) begin bad++; $display("FAIL bp_hold got=%h/%b/%0d exp=aaaa/0/10", dataOut, inReady, writeBackAddrOut); end
    outReady = 1'b1;
    @(negedge clk);
    total++; if (dataOut !== 32'hBBBB || outValid !== 1'b1 || inReady !== 1'b1) begin bad++; $display("FAIL bp_rel_b got=%h/%b/%b exp=bbbb/1/1", dataOut, outValid, inReady); end
    @(negedge clk);
    idle();
    total++; if (dataOut !== 32'hCCCC || outValid !== 1'b1 || writeBackAddrOut !== 5'd12) begin bad++; $display("FAIL bp_rel_c got=%h/%b/%0d exp=cccc/1/12", dataOut, outValid, writeBackAddrOut); end
    @(negedge clk);
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", outValid); end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    drive(1'b1, 32'h4000, 32'h11, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    @(negedge clk);
    drive(1'b1, 32'h4004, 32'h22, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    @(negedge clk);
    total++; if (inReady !== 1'b0 || dataCacheWriteEnableOut !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b/%b exp=0/1", inReady, dataCacheWriteEnableOut); end
    drive(1'b1, 32'h4008, 32'h33, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (outValid !== 1'b0 || inReady !== 1'b1) begin bad++; $display("FAIL flush_clear got=%b/%b exp=0/1", outValid, inReady); end
    total++; if (dataCacheWriteEnableOut !== 1'b0 || dataCacheReadEnableOut !== 1'b0 || byteEnableOut !== 4'h0) begin bad++; $display("FAIL flush_strobe got=%b/%b/%h exp=0/0/0", dataCacheWriteEnableOut, dataCacheReadEnableOut, byteEnableOut); end
    idle();
    outReady = 1'b1;
    @(negedge clk);
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", outValid); end
  endtask

  task automatic test_async_reset();
    outReady = 1'b0;
    drive(1'b1, 32'h5555, 32'h0, 1'b1, 1'b0, 1'b1, 2'd2, 5'd3);
    @(negedge clk);
    drive(1'b1, 32'h6666, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd6);
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (outValid !== 1'b0 || inReady !== 1'b1) begin bad++; $display("FAIL areset_valid got=%b/%b exp=0/1", outValid, inReady); end
    total++; if (dataOut !== 32'h0 || byteEnableOut !== 4'h0 || writeBackAddrOut !== 5'd0 || fwdValid !== 1'b0) begin bad++; $display("FAIL areset_data got=%h/%h/%0d/%b exp=0/0/0/0", dataOut, byteEnableOut, writeBackAddrOut, fwdValid); end
    @(negedge clk);
    rst_n = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL areset_discard got=%b exp=0", outValid); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_store_lanes();
    test_load_and_x0();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
